pio_sm_core: RTL and testbench

PIO_SM_CORE -- requirements
Module: pio_sm_core

---
 rtl/pio_sm_core.sv | 273 +++++++++++++++++++++++++++
 tb/tb_pio_sm_core.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_sm_core.sv
// Single PIO-style state machine core: decodes and retires one 16-bit instruction per clock.
// Optional autopull on OUT is enabled by defining PIO_AUTOPULL_EN.
module pio_sm_core #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sm_en,
  input  logic [15:0]       instr,
  input  logic [PC_W-1:0]   wrap_top,
  input  logic [PC_W-1:0]   wrap_bottom,
  input  logic [4:0]        pull_thresh,
  input  logic              shift_right,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_pop,
  input  logic              rx_full,
  output logic              rx_push,
  output logic [DATA_W-1:0] rx_data,
  output logic [PC_W-1:0]   pc,
  output logic              stalled,
  output logic [DATA_W-1:0] x_out,
  output logic [DATA_W-1:0] y_out
);

  localparam int                  CNT_W    = 6;
  localparam logic [CNT_W-1:0]    FULL_CNT = CNT_W'(DATA_W);
  localparam logic [DATA_W-1:0]   ZERO     = '0;
  localparam logic [DATA_W-1:0]   ONES     = '1;

  typedef enum logic [2:0] {
    OP_JMP      = 3'b000,
    OP_WAIT     = 3'b001,
    OP_IN       = 3'b010,
    OP_OUT      = 3'b011,
    OP_PUSHPULL = 3'b100,
    OP_MOV      = 3'b101,
    OP_IRQ      = 3'b110,
    OP_SET      = 3'b111
  } opcode_t;

  logic [PC_W-1:0]   r_pc;
  logic [DATA_W-1:0] r_x;
  logic [DATA_W-1:0] r_y;
  logic [DATA_W-1:0] r_osr;
  logic [DATA_W-1:0] r_isr;
  logic [CNT_W-1:0]  r_osr_cnt;
  logic [CNT_W-1:0]  r_isr_cnt;

  opcode_t           w_op;
  logic [2:0]        w_field;
  logic [CNT_W-1:0]  w_n;
  logic [CNT_W-1:0]  w_thresh;
  logic              w_unused;

  assign w_op     = opcode_t'(instr[15:13]);
  assign w_field  = instr[7:5];
  assign w_n      = (instr[4:0] == 5'd0 || {1'b0, instr[4:0]} > FULL_CNT) ? FULL_CNT
                                                                         : {1'b0, instr[4:0]};
  assign w_thresh = (pull_thresh == 5'd0) ? FULL_CNT : {1'b0, pull_thresh};
  // Instruction bits 12:8 carry no function in this core; they are reduced to a dummy signal.
  assign w_unused = ^instr[12:8];

  // OSR as seen by the OUT shifter: either the held value or a freshly autopulled word.
  logic [DATA_W-1:0] w_osr_src;
  logic [CNT_W-1:0]  w_osr_cnt_src;
  logic              w_ap_pop;
  logic              w_ap_stall;

`ifdef PIO_AUTOPULL_EN
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_osr_src     = r_osr;
    w_osr_cnt_src = r_osr_cnt;
    w_ap_pop      = 1'b0;
    w_ap_stall    = 1'b0;
    if (w_op == OP_OUT && r_osr_cnt >= w_thresh) begin
      if (tx_valid) begin
        w_osr_src     = tx_data;
        w_osr_cnt_src = '0;
        w_ap_pop      = 1'b1;
      end else begin
        w_ap_stall    = 1'b1;
      end
    end
  end
`else
  assign w_osr_src     = r_osr;
  assign w_osr_cnt_src = r_osr_cnt;
  assign w_ap_pop      = 1'b0;
  assign w_ap_stall    = 1'b0;
`endif

  logic [DATA_W-1:0]   w_mask;
  logic [2*DATA_W-1:0] w_osr_left_ext;
  logic [DATA_W-1:0]   w_out_data;
  logic [DATA_W-1:0]   w_osr_shifted;
  logic [DATA_W-1:0]   w_in_src;
  logic [CNT_W-1:0]    w_fill_sh;
  logic [DATA_W-1:0]   w_isr_shifted;
  logic [CNT_W:0]      w_osr_sum;
  logic [CNT_W:0]      w_isr_sum;
  logic [CNT_W-1:0]    w_osr_cnt_sat;
  logic [CNT_W-1:0]    w_isr_cnt_sat;

  // Shifts by DATA_W yield zero, so n == DATA_W needs no special casing.
  assign w_mask         = ~(ONES << w_n);
  assign w_osr_left_ext = {ZERO, w_osr_src} << w_n;
  assign w_out_data     = shift_right ? (w_osr_src & w_mask) : w_osr_left_ext[2*DATA_W-1:DATA_W];
  assign w_osr_shifted  = shift_right ? (w_osr_src >> w_n)   : w_osr_left_ext[DATA_W-1:0];

  always_comb begin
    w_in_src = ZERO;
    case (w_field)
      3'b001:  w_in_src = r_x;
      3'b010:  w_in_src = r_y;
      default: w_in_src = ZERO;
    endcase
  end

  assign w_fill_sh     = FULL_CNT - w_n;
  assign w_isr_shifted = shift_right ? ((r_isr >> w_n) | (w_in_src << w_fill_sh))
                                     : ((r_isr << w_n) | (w_in_src & w_mask));

  assign w_osr_sum     = {1'b0, w_osr_cnt_src} + {1'b0, w_n};
  assign w_isr_sum     = {1'b0, r_isr_cnt} + {1'b0, w_n};
  assign w_osr_cnt_sat = (w_osr_sum > {1'b0, FULL_CNT}) ? FULL_CNT : w_osr_sum[CNT_W-1:0];
  assign w_isr_cnt_sat = (w_isr_sum > {1'b0, FULL_CNT}) ? FULL_CNT : w_isr_sum[CNT_W-1:0];

  logic [PC_W-1:0]   w_pc_nxt;
  logic [DATA_W-1:0] w_x_nxt;
  logic [DATA_W-1:0] w_y_nxt;
  logic [DATA_W-1:0] w_osr_nxt;
  logic [DATA_W-1:0] w_isr_nxt;
  logic [CNT_W-1:0]  w_osr_cnt_nxt;
  logic [CNT_W-1:0]  w_isr_cnt_nxt;
  logic [DATA_W-1:0] w_mov_val;
  logic              w_mov_ok;
  logic              w_taken;
  logic              w_stall;
  logic              w_pop;
  logic              w_push;
  logic              w_retire;

  always_comb begin
    w_x_nxt       = r_x;
    w_y_nxt       = r_y;
    w_osr_nxt     = r_osr;
    w_isr_nxt     = r_isr;
    w_osr_cnt_nxt = r_osr_cnt;
    w_isr_cnt_nxt = r_isr_cnt;
    w_mov_val     = ZERO;
    w_mov_ok      = 1'b0;
    w_taken       = 1'b0;
    w_stall       = w_ap_stall;
    w_pop         = w_ap_pop;
    w_push        = 1'b0;

    case (w_op)
      OP_JMP: begin
        case (w_field)
          3'b000: w_taken = 1'b1;
          3'b001: w_taken = (r_x == ZERO);
          3'b010: begin
            w_taken = (r_x != ZERO);
            w_x_nxt = r_x - DATA_W'(1);
          end
          3'b011: w_taken = (r_y == ZERO);
          3'b100: begin
            w_taken = (r_y != ZERO);
            w_y_nxt = r_y - DATA_W'(1);
          end
          3'b101: w_taken = (r_x != r_y);
          3'b110: w_taken = 1'b0;
          default: w_taken = (r_osr_cnt < w_thresh);
        endcase
      end
      OP_IN: begin
        w_isr_nxt     = w_isr_shifted;
        w_isr_cnt_nxt = w_isr_cnt_sat;
      end
      OP_OUT: begin
        w_osr_nxt     = w_osr_shifted;
        w_osr_cnt_nxt = w_osr_cnt_sat;
        if (w_field == 3'b001)      w_x_nxt = w_out_data;
        else if (w_field == 3'b010) w_y_nxt = w_out_data;
      end
      OP_PUSHPULL: begin
        if (instr[7]) begin
          // IfEmpty PULL retires untouched while the OSR still holds unshifted data.
          if (!(instr[6] && r_osr_cnt < w_thresh)) begin
            if (tx_valid) begin
              w_osr_nxt     = tx_data;
              w_osr_cnt_nxt = '0;
              w_pop         = 1'b1;
            end else if (instr[5]) begin
              w_stall       = 1'b1;
            end else begin
              w_osr_nxt     = r_x;
              w_osr_cnt_nxt = '0;
            end
          end
        end else begin
          if (!(instr[6] && r_isr_cnt < FULL_CNT)) begin
            if (!rx_full) begin
              w_push        = 1'b1;
              w_isr_nxt     = ZERO;
              w_isr_cnt_nxt = '0;
            end else if (instr[5]) begin
              w_stall       = 1'b1;
            end
          end
        end
      end
      OP_MOV: begin
        case (instr[2:0])
          3'b001:  begin w_mov_val = r_x;   w_mov_ok = 1'b1; end
          3'b010:  begin w_mov_val = r_y;   w_mov_ok = 1'b1; end
          3'b011:  begin w_mov_val = ZERO;  w_mov_ok = 1'b1; end
          3'b110:  begin w_mov_val = r_isr; w_mov_ok = 1'b1; end
          3'b111:  begin w_mov_val = r_osr; w_mov_ok = 1'b1; end
          default: begin w_mov_val = ZERO;  w_mov_ok = 1'b0; end
        endcase
        if (w_mov_ok && w_field == 3'b001)      w_x_nxt = w_mov_val;
        else if (w_mov_ok && w_field == 3'b010) w_y_nxt = w_mov_val;
      end
      OP_SET: begin
        if (w_field == 3'b001)      w_x_nxt = DATA_W'(instr[4:0]);
        else if (w_field == 3'b010) w_y_nxt = DATA_W'(instr[4:0]);
      end
      default: ;
    endcase

    // A taken jump bypasses the wrap window entirely.
    if (w_taken)                  w_pc_nxt = instr[PC_W-1:0];
    else if (r_pc == wrap_bottom) w_pc_nxt = wrap_top;
    else                          w_pc_nxt = r_pc + PC_W'(1);
  end

  assign w_retire = sm_en & ~w_stall;

  // Strobes are qualified by rst so they drop the moment reset asserts.
  assign stalled = rst & sm_en & w_stall;
  assign tx_pop  = rst & sm_en & w_pop;
  assign rx_push = rst & sm_en & w_push;
  assign rx_data = r_isr;
  assign pc      = r_pc;
  assign x_out   = r_x;
  assign y_out   = r_y;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc      <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_osr     <= '0;
      r_isr     <= '0;
      r_osr_cnt <= FULL_CNT;
      r_isr_cnt <= '0;
    end else if (w_retire) begin
      r_pc      <= w_pc_nxt;
      r_x       <= w_x_nxt;
      r_y       <= w_y_nxt;
      r_osr     <= w_osr_nxt;
      r_isr     <= w_isr_nxt;
      r_osr_cnt <= w_osr_cnt_nxt;
      r_isr_cnt <= w_isr_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_pio_sm_core.sv
// Directed self-checking bench for pio_sm_core; autopull scenario follows PIO_AUTOPULL_EN.
module tb_pio_sm_core;
  localparam int DATA_W = 32;
  localparam int PC_W   = 5;

  localparam logic [15:0] NOP        = 16'h2000;
  localparam logic [15:0] SET_X      = 16'hE020;
  localparam logic [15:0] SET_Y      = 16'hE040;
  localparam logic [15:0] PULL_B     = 16'h80A0;
  localparam logic [15:0] PULL_NB    = 16'h8080;
  localparam logic [15:0] PULL_IFE_B = 16'h80E0;
  localparam logic [15:0] PUSH_B     = 16'h8020;
  localparam logic [15:0] PUSH_NB    = 16'h8000;
  localparam logic [15:0] PUSH_IFF_B = 16'h8060;
  localparam logic [15:0] OUT_X      = 16'h6020;
  localparam logic [15:0] OUT_Y      = 16'h6040;
  localparam logic [15:0] OUT_NULL   = 16'h6060;
  localparam logic [15:0] IN_X       = 16'h4020;
  localparam logic [15:0] IN_Y       = 16'h4040;
  localparam logic [15:0] MOV_X_Y    = 16'hA022;
  localparam logic [15:0] MOV_X_ZERO = 16'hA023;
  localparam logic [15:0] MOV_X_OSR  = 16'hA027;
  localparam logic [15:0] MOV_Y_OSR  = 16'hA047;
  localparam logic [15:0] MOV_Y_ISR  = 16'hA046;

  logic              clk = 1'b0;
  logic              rst, sm_en, shift_right, tx_valid, rx_full;
  logic [15:0]       instr;
  logic [PC_W-1:0]   wrap_top, wrap_bottom, pc;
  logic [4:0]        pull_thresh;
  logic [DATA_W-1:0] tx_data, rx_data, x_out, y_out;
  logic              tx_pop, rx_push, stalled;

  int              n_chk  = 0;
  int              n_fail = 0;
  logic [PC_W-1:0] exp_pc = '0;

  pio_sm_core #(.DATA_W(DATA_W), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .sm_en(sm_en), .instr(instr),
    .wrap_top(wrap_top), .wrap_bottom(wrap_bottom), .pull_thresh(pull_thresh),
    .shift_right(shift_right), .tx_valid(tx_valid), .tx_data(tx_data), .tx_pop(tx_pop),
    .rx_full(rx_full), .rx_push(rx_push), .rx_data(rx_data), .pc(pc),
    .stalled(stalled), .x_out(x_out), .y_out(y_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [15:0] ins);
    instr = ins;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire();
    tick();
    exp_pc = (exp_pc == wrap_bottom) ? wrap_top : exp_pc + 1'b1;
  endtask

  task automatic step(input logic [15:0] ins);
    drive(ins);
    retire();
  endtask

  task automatic test_reset();
    rst = 1'b1; sm_en = 1'b1; instr = PULL_B; wrap_top = '0; wrap_bottom = 5'd31;
    pull_thresh = '0; shift_right = 1'b1; tx_valid = 1'b0; tx_data = '0; rx_full = 1'b0;
    #1 rst = 1'b0;
    #2;
    n_chk++; if (pc !== 5'd0) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, 5'd0); end
    n_chk++; if (x_out !== 32'h0) begin n_fail++; $display("FAIL reset_x: got %h expected %h", x_out, 32'h0); end
    n_chk++; if (y_out !== 32'h0) begin n_fail++; $display("FAIL reset_y: got %h expected %h", y_out, 32'h0); end
    n_chk++; if (rx_data !== 32'h0) begin n_fail++; $display("FAIL reset_rx_data: got %h expected %h", rx_data, 32'h0); end
    n_chk++; if ({stalled, tx_pop, rx_push} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes: got %b expected %b", {stalled, tx_pop, rx_push}, 3'b000); end
    @(negedge clk);
    sm_en = 1'b0; instr = NOP; rst = 1'b1;
    tick();
    exp_pc = '0;
  endtask

  task automatic test_sm_en_hold();
    sm_en = 1'b0;
    drive(SET_X | 16'd5);
    tick();
    n_chk++; if (x_out !== 32'h0) begin n_fail++; $display("FAIL hold_x: got %h expected %h", x_out, 32'h0); end
    n_chk++; if (pc !== exp_pc) begin n_fail++; $display("FAIL hold_pc: got %h expected %h", pc, exp_pc); end
    tx_valid = 1'b1;
    drive(PULL_B);
    n_chk++; if (tx_pop !== 1'b0) begin n_fail++; $display("FAIL hold_tx_pop: got %b expected %b", tx_pop, 1'b0); end
    tx_valid = 1'b0;
    #1;
    n_chk++; if (stalled !== 1'b0) begin n_fail++; $display("FAIL hold_stalled: got %b expected %b", stalled, 1'b0); end
  endtask

  task automatic test_jmp_loop();
    int iters = 0;
    wrap_bottom = 5'd1; wrap_top = 5'd7; sm_en = 1'b1;
    step(SET_X | 16'd5);
    n_chk++; if (x_out !== 32'd5) begin n_fail++; $display("FAIL set_x: got %h expected %h", x_out, 32'd5); end
    drive(16'h0041);
    for (int i = 0; i < 20; i++) begin
      tick();
      iters++;
      if (pc !== 5'd1) break;
    end
    exp_pc = 5'd7;
    n_chk++; if (iters !== 6) begin n_fail++; $display("FAIL jmp_iters: got %0d expected %0d", iters, 6); end
    n_chk++; if (x_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL jmp_x_final: got %h expected %h", x_out, 32'hFFFF_FFFF); end
    n_chk++; if (pc !== exp_pc) begin n_fail++; $display("FAIL jmp_exit_pc: got %h expected %h", pc, exp_pc); end
    wrap_bottom = 5'd31; wrap_top = 5'd0;
  endtask

  task automatic test_pull_out();
    shift_right = 1'b1; tx_valid = 1'b1; tx_data = 32'hA5A5_0F0F;
    drive(PULL_B);
    n_chk++; if ({tx_pop, stalled} !== 2'b10) begin n_fail++; $display("FAIL pull_pop: got %b expected %b", {tx_pop, stalled}, 2'b10); end
    retire();
    drive(OUT_X | 16'd8);
    n_chk++; if (tx_pop !== 1'b0) begin n_fail++; $display("FAIL pull_pop_once: got %b expected %b", tx_pop, 1'b0); end
    retire();
    n_chk++; if (x_out !== 32'h0000_000F) begin n_fail++; $display("FAIL out_x8: got %h expected %h", x_out, 32'h0000_000F); end
    step(MOV_Y_OSR);
    n_chk++; if (y_out !== 32'h00A5_A50F) begin n_fail++; $display("FAIL osr_after_right: got %h expected %h", y_out, 32'h00A5_A50F); end
    shift_right = 1'b0;
    step(OUT_Y | 16'd12);
    n_chk++; if (y_out !== 32'h0000_000A) begin n_fail++; $display("FAIL out_left12: got %h expected %h", y_out, 32'h0000_000A); end
    step(MOV_X_OSR);
    n_chk++; if (x_out !== 32'h5A50_F000) begin n_fail++; $display("FAIL osr_after_left: got %h expected %h", x_out, 32'h5A50_F000); end
    drive(16'h00E3);
    tick();
    exp_pc = 5'd3;
    n_chk++; if (pc !== exp_pc) begin n_fail++; $display("FAIL jmp_osre_taken: got %h expected %h", pc, exp_pc); end
    step(OUT_NULL);
    step(16'h00EA);
    n_chk++; if (pc !== exp_pc) begin n_fail++; $display("FAIL jmp_osre_not_taken: got %h expected %h", pc, exp_pc); end
    step(MOV_Y_OSR);
    n_chk++; if (y_out !== 32'h0) begin n_fail++; $display("FAIL out32_empty: got %h expected %h", y_out, 32'h0); end
  endtask

  task automatic test_pull_stall();
    tx_valid = 1'b0;
    drive(PULL_B);
    for (int i = 0; i < 4; i++) begin
      n_chk++; if ({stalled, tx_pop} !== 2'b10) begin n_fail++; $display("FAIL pull_stall_%0d: got %b expected %b", i, {stalled, tx_pop}, 2'b10); end
      n_chk++; if (pc !== exp_pc) begin n_fail++; $display("FAIL pull_stall_pc_%0d: got %h expected %h", i, pc, exp_pc); end
      tick();
    end
    tx_valid = 1'b1; tx_data = 32'h1234_5678;
    #1;
    n_chk++; if ({stalled, tx_pop} !== 2'b01) begin n_fail++; $display("FAIL pull_release: got %b expected %b", {stalled, tx_pop}, 2'b01); end
    retire();
    n_chk++; if (pc !== exp_pc) begin n_fail++; $display("FAIL pull_retire_pc: got %h expected %h", pc, exp_pc); end
    tx_data = 32'hDEAD_BEEF;
    drive(PULL_IFE_B);
    n_chk++; if ({stalled, tx_pop} !== 2'b00) begin n_fail++; $display("FAIL pull_ifempty: got %b expected %b", {stalled, tx_pop}, 2'b00); end
    retire();
    step(MOV_Y_OSR);
    n_chk++; if (y_out !== 32'h1234_5678) begin n_fail++; $display("FAIL pull_ifempty_osr: got %h expected %h", y_out, 32'h1234_5678); end
    tx_valid = 1'b0;
    step(SET_X | 16'd9);
    drive(PULL_NB);
    n_chk++; if ({stalled, tx_pop} !== 2'b00) begin n_fail++; $display("FAIL pull_nb: got %b expected %b", {stalled, tx_pop}, 2'b00); end
    retire();
    step(MOV_Y_OSR);
    n_chk++; if (y_out !== 32'd9) begin n_fail++; $display("FAIL pull_nb_x: got %h expected %h", y_out, 32'd9); end
  endtask

  task automatic test_push();
    shift_right = 1'b0;
    step(SET_X | 16'h15);
    step(IN_X | 16'd8);
    rx_full = 1'b1;
    drive(PUSH_B);
    n_chk++; if ({stalled, rx_push} !== 2'b10) begin n_fail++; $display("FAIL push_block_full: got %b expected %b", {stalled, rx_push}, 2'b10); end
    tick();
    n_chk++; if (pc !== exp_pc) begin n_fail++; $display("FAIL push_stall_pc: got %h expected %h", pc, exp_pc); end
    drive(PUSH_NB);
    n_chk++; if ({stalled, rx_push} !== 2'b00) begin n_fail++; $display("FAIL push_nb_full: got %b expected %b", {stalled, rx_push}, 2'b00); end
    retire();
    n_chk++; if (pc !== exp_pc) begin n_fail++; $display("FAIL push_nb_pc: got %h expected %h", pc, exp_pc); end
    step(MOV_Y_ISR);
    n_chk++; if (y_out !== 32'h15) begin n_fail++; $display("FAIL push_isr_kept: got %h expected %h", y_out, 32'h15); end
    rx_full = 1'b0;
    drive(PUSH_B);
    n_chk++; if ({rx_push, rx_data} !== {1'b1, 32'h15}) begin n_fail++; $display("FAIL push_data: got %b/%h expected %b/%h", rx_push, rx_data, 1'b1, 32'h15); end
    retire();
    step(MOV_Y_ISR);
    n_chk++; if (y_out !== 32'h0) begin n_fail++; $display("FAIL push_clears_isr: got %h expected %h", y_out, 32'h0); end
    step(IN_X | 16'd8);
    drive(PUSH_IFF_B);
    n_chk++; if ({stalled, rx_push} !== 2'b00) begin n_fail++; $display("FAIL push_iffull_low: got %b expected %b", {stalled, rx_push}, 2'b00); end
    retire();
    step(SET_Y | 16'd3);
    step(IN_Y);
    drive(PUSH_IFF_B);
    n_chk++; if ({rx_push, rx_data} !== {1'b1, 32'h3}) begin n_fail++; $display("FAIL push_iffull_full: got %b/%h expected %b/%h", rx_push, rx_data, 1'b1, 32'h3); end
    retire();
    shift_right = 1'b1;
    step(SET_X | 16'd31);
    step(IN_X | 16'd4);
    step(MOV_Y_ISR);
    n_chk++; if (y_out !== 32'hF000_0000) begin n_fail++; $display("FAIL in_right4: got %h expected %h", y_out, 32'hF000_0000); end
  endtask

  task automatic test_set_mov_jmp();
    step(SET_Y | 16'd7);
    step(MOV_X_Y);
    n_chk++; if (x_out !== 32'd7) begin n_fail++; $display("FAIL mov_x_y: got %h expected %h", x_out, 32'd7); end
    step(16'h00BF);
    n_chk++; if (pc !== exp_pc) begin n_fail++; $display("FAIL jmp_xney_not_taken: got %h expected %h", pc, exp_pc); end
    step(MOV_X_ZERO);
    n_chk++; if (x_out !== 32'h0) begin n_fail++; $display("FAIL mov_x_zero: got %h expected %h", x_out, 32'h0); end
    drive(16'h00BF);
    tick();
    exp_pc = 5'd31;
    n_chk++; if (pc !== exp_pc) begin n_fail++; $display("FAIL jmp_xney_taken: got %h expected %h", pc, exp_pc); end
    drive(16'h0091);
    tick();
    exp_pc = 5'd17;
    n_chk++; if ({pc, y_out} !== {5'd17, 32'd6}) begin n_fail++; $display("FAIL jmp_ydec: got %h/%h expected %h/%h", pc, y_out, 5'd17, 32'd6); end
    step(16'h0062);
    n_chk++; if (pc !== exp_pc) begin n_fail++; $display("FAIL jmp_yzero_not_taken: got %h expected %h", pc, exp_pc); end
  endtask

  task automatic test_wrap();
    logic [PC_W-1:0] seq [6] = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
    drive(16'h0000);
    tick();
    exp_pc = '0;
    wrap_bottom = 5'd3; wrap_top = 5'd1;
    n_chk++; if (pc !== 5'd0) begin n_fail++; $display("FAIL wrap_start: got %h expected %h", pc, 5'd0); end
    for (int i = 0; i < 6; i++) begin
      step(NOP);
      n_chk++; if (pc !== seq[i]) begin n_fail++; $display("FAIL wrap_seq_%0d: got %h expected %h", i, pc, seq[i]); end
    end
    wrap_bottom = 5'd31; wrap_top = 5'd0;
  endtask

  task automatic test_out_pull_mode();
    tx_valid = 1'b1; tx_data = 32'h1122_3344; shift_right = 1'b1; pull_thresh = 5'd0;
    step(PULL_B);
    for (int i = 0; i < 4; i++) step(OUT_NULL | 16'd8);
    tx_data = 32'hCAFE_BABE;
    drive(OUT_X | 16'd8);
`ifdef PIO_AUTOPULL_EN
    n_chk++; if ({tx_pop, stalled} !== 2'b10) begin n_fail++; $display("FAIL autopull_pop: got %b expected %b", {tx_pop, stalled}, 2'b10); end
    retire();
    n_chk++; if (x_out !== 32'h0000_00BE) begin n_fail++; $display("FAIL autopull_x: got %h expected %h", x_out, 32'h0000_00BE); end
    step(OUT_NULL | 16'd24);
    tx_valid = 1'b0;
    drive(OUT_X | 16'd8);
    n_chk++; if ({tx_pop, stalled} !== 2'b01) begin n_fail++; $display("FAIL autopull_stall: got %b expected %b", {tx_pop, stalled}, 2'b01); end
    tick();
    n_chk++; if (pc !== exp_pc) begin n_fail++; $display("FAIL autopull_stall_pc: got %h expected %h", pc, exp_pc); end
    tx_valid = 1'b1; tx_data = 32'h0000_00A7;
    retire();
    n_chk++; if (x_out !== 32'h0000_00A7) begin n_fail++; $display("FAIL autopull_resume_x: got %h expected %h", x_out, 32'h0000_00A7); end
`else
    n_chk++; if ({tx_pop, stalled} !== 2'b00) begin n_fail++; $display("FAIL out_no_pop: got %b expected %b", {tx_pop, stalled}, 2'b00); end
    retire();
    n_chk++; if (x_out !== 32'h0) begin n_fail++; $display("FAIL out_empty_x: got %h expected %h", x_out, 32'h0); end
    tx_valid = 1'b0;
    drive(OUT_X | 16'd8);
    n_chk++; if (stalled !== 1'b0) begin n_fail++; $display("FAIL out_no_stall: got %b expected %b", stalled, 1'b0); end
    retire();
`endif
    tx_valid = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    tx_valid = 1'b0;
    drive(PULL_B);
    n_chk++; if (stalled !== 1'b1) begin n_fail++; $display("FAIL rst_pre_stall: got %b expected %b", stalled, 1'b1); end
    rst = 1'b0;
    #1;
    n_chk++; if ({pc, x_out, y_out, rx_data} !== {5'd0, 96'h0}) begin n_fail++; $display("FAIL rst_mid_regs: got %h/%h/%h/%h expected zeros", pc, x_out, y_out, rx_data); end
    n_chk++; if ({stalled, tx_pop, rx_push} !== 3'b000) begin n_fail++; $display("FAIL rst_mid_strobes: got %b expected %b", {stalled, tx_pop, rx_push}, 3'b000); end
    instr = SET_X | 16'd3;
    tick();
    @(negedge clk);
    rst = 1'b1;
    exp_pc = '0;
    retire();
    n_chk++; if ({pc, x_out} !== {5'd1, 32'd3}) begin n_fail++; $display("FAIL rst_resume: got %h/%h expected %h/%h", pc, x_out, 5'd1, 32'd3); end
  endtask

  initial begin
    test_reset();
    test_sm_en_hold();
    test_jmp_loop();
    test_pull_out();
    test_pull_stall();
    test_push();
    test_set_mov_jmp();
    test_wrap();
    test_out_pull_mode();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
